// File: rtl/ps2_host_tx_if.sv
// Command handshake plus PS/2 pad levels and pull-down enables shared by the
// game logic, the host transmitter and the top-level open-collector pads.
`timescale 1ns/1ps
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_done;
   logic       tx_error;

   modport slave (
      input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
      output tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_error
   );

   modport master (
      output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
      input  tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bits shifted out on device
// clock falling edges, acknowledge check, and a whole-frame timeout.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input logic          clk,
   input logic          rst,
   ps2_host_tx_if.slave bus
);
   localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA, S_STOP, S_ACK, S_WAIT_IDLE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0]    shift_q, shift_d;
   logic [3:0]    idx_q, idx_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          clk_meta_q, clk_sync_q, clk_prev_q;
   logic          data_meta_q, data_sync_q;
   logic          fe, ready, in_frame;

   // Sync flops reset to the idle (pulled-up) line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= bus.ps2_clk_in;
         clk_sync_q  <= clk_meta_q;
         clk_prev_q  <= clk_sync_q;
         data_meta_q <= bus.ps2_data_in;
         data_sync_q <= data_meta_q;
      end
   end

   assign fe       = clk_prev_q & ~clk_sync_q;
   // The pulse cycle is not yet ready, so IDLE always follows a done/error pulse.
   assign ready    = (state_q == S_IDLE) && !done_q && !error_q;
   assign in_frame = (state_q inside {S_START, S_DATA, S_STOP, S_ACK, S_WAIT_IDLE});

   always_comb begin
      // NOTE: every target gets its default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            data_oe_d = 1'b0;
            if (bus.tx_valid && ready) begin
               state_d = S_INHIBIT;
               cnt_d   = '0;
               shift_d = {~^bus.tx_data, bus.tx_data};
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               state_d   = S_REQ;
               cnt_d     = '0;
               data_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_REQ: begin
            state_d = S_START;
            cnt_d   = '0;
         end
         // Our own clock release must not look like a device falling edge.
         S_START: begin
            if (clk_sync_q) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (fe) begin
               data_oe_d = ~shift_q[idx_q];
               idx_d     = idx_q + 4'd1;
               if (idx_q == 4'd8) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fe) begin
               data_oe_d = 1'b0;
               state_d   = S_ACK;
            end
         end
         S_ACK: begin
            if (fe) begin
               if (data_sync_q) begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_sync_q && data_sync_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout wins over any edge seen in the same cycle.
      if (in_frame) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == TIMEOUT_LAST) begin
            state_d   = S_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
         end
      end

      clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         idx_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign bus.tx_ready    = ready;
   assign bus.ps2_clk_oe  = clk_oe_q;
   assign bus.ps2_data_oe = data_oe_q;
   assign bus.tx_done     = done_q;
   assign bus.tx_error    = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench: a device model clocks frames out of the host and acks/nacks;
// a second instance with no device exercises the frame timeout.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INHIBIT      = 20;
   localparam int TIMEOUT_MAIN = 3000;
   localparam int TIMEOUT_TO   = 500;
   localparam int HALF         = 40;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ps2_host_tx_if bus ();
   ps2_host_tx_if bus_to ();

   logic dev_clk_low, dev_data_low;
   assign bus.ps2_clk_in     = ~(bus.ps2_clk_oe | dev_clk_low);
   assign bus.ps2_data_in    = ~(bus.ps2_data_oe | dev_data_low);
   assign bus_to.ps2_clk_in  = ~bus_to.ps2_clk_oe;
   assign bus_to.ps2_data_in = ~bus_to.ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT_MAIN)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT_TO)) dut_to (
      .clk(clk), .rst(rst), .bus(bus_to)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse monitor on the main instance.
   int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int   post_seen = 0, post_bad = 0, done_cyc = 0, rise_cyc = 0;
   logic pulse_prev = 1'b0, clk_oe_prev = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (pulse_prev) begin
         post_seen++;
         if (!bus.tx_ready || bus.tx_done || bus.tx_error) post_bad++;
      end
      pulse_prev = bus.tx_done | bus.tx_error;
      if (bus.tx_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.tx_error) err_cnt++;
      if (bus.tx_done && bus.tx_error) both_cnt++;
      if (bus.ps2_clk_oe && !clk_oe_prev) rise_cyc = cyc;
      clk_oe_prev = bus.ps2_clk_oe;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, got no end, expected end");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   // bits[i] is the line level at the device rising edge after fe(i+1):
   // [7:0] data, [8] parity, [9] stop, [10] ack.
   task automatic dev_frame(input logic ack, output logic [10:0] bits,
                            output int clk_low, output int req_cyc, output logic start_bit);
      int t = 0;
      bits = '1; clk_low = 0; req_cyc = 0; start_bit = 1'b1;
      while (!bus.ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
      while (bus.ps2_clk_oe && t < 10000) begin
         clk_low++;
         if (bus.ps2_data_oe) req_cyc++;
         @(negedge clk);
         t++;
      end
      repeat (10) @(negedge clk);
      start_bit = bus.ps2_data_in;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) dev_data_low = ack;
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         bits[i] = bus.ps2_data_in;
         repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_outcome(input int d0, input int e0);
      int t = 0;
      while (done_cnt == d0 && err_cnt == e0 && t < 200) begin @(posedge clk); t++; end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      logic [10:0] bits;
      int          clow, reqc, d0, e0, b2b_done, n, t;
      logic        startb, got;

      rst = 1'b0;
      bus.tx_data = '0;    bus.tx_valid = 1'b0;
      bus_to.tx_data = '0; bus_to.tx_valid = 1'b0;
      dev_clk_low = 1'b0;  dev_data_low = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", bus.tx_ready, 1);
      check("rst_clk_oe", bus.ps2_clk_oe, 0);
      check("rst_data_oe", bus.ps2_data_oe, 0);
      check("rst_done", bus.tx_done, 0);
      check("rst_error", bus.tx_error, 0);

      // 0xED: parity 1, device acks.
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      check("ed_accept_clk_oe", bus.ps2_clk_oe, 1);
      check("ed_ready_low", bus.tx_ready, 0);
      dev_frame(1'b1, bits, clow, reqc, startb);
      wait_outcome(d0, e0);
      check("ed_clk_low_cycles", clow, INHIBIT + 1);
      check("ed_req_cycles", reqc, 1);
      check("ed_start_bit", startb, 0);
      check("ed_frame", bits, 11'h3ED);   // ack 0, stop 1, parity 1, 0xED
      check("ed_done", done_cnt - d0, 1);
      check("ed_no_error", err_cnt - e0, 0);

      // 0xF4: parity 0, device acks.
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      dev_frame(1'b1, bits, clow, reqc, startb);
      wait_outcome(d0, e0);
      check("f4_frame", bits, 11'h2F4);   // ack 0, stop 1, parity 0, 0xF4
      check("f4_done", done_cnt - d0, 1);
      check("f4_no_error", err_cnt - e0, 0);

      // 0x01 with NACK: parity 0, ack line stays high.
      d0 = done_cnt; e0 = err_cnt;
      send(8'h01);
      dev_frame(1'b0, bits, clow, reqc, startb);
      wait_outcome(d0, e0);
      check("nack_frame", bits, 11'h601); // ack 1, stop 1, parity 0, 0x01
      check("nack_error", err_cnt - e0, 1);
      check("nack_no_done", done_cnt - d0, 0);
      check("nack_idle", bus.tx_ready, 1);

      // Back-to-back: valid held high, data switched to 0x00 mid-transfer.
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk);
      bus.tx_data  = 8'hFF;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_data  = 8'h00;
      dev_frame(1'b1, bits, clow, reqc, startb);
      check("b2b_first_frame", bits, 11'h3FF); // ack 0, stop 1, parity 1, 0xFF
      t = 0;
      while (done_cnt == d0 && t < 200) begin @(posedge clk); t++; end
      check("b2b_first_done", done_cnt - d0, 1);
      b2b_done = done_cyc;
      fork
         dev_frame(1'b1, bits, clow, reqc, startb);
         begin
            for (int k = 0; k < 100; k++) begin
               @(negedge clk);
               if (bus.ps2_clk_oe) break;
            end
            bus.tx_valid = 1'b0;
         end
      join
      wait_outcome(d0 + 1, e0);
      check("b2b_accept_gap", rise_cyc - b2b_done, 2);
      check("b2b_second_clk_low", clow, INHIBIT + 1);
      check("b2b_second_frame", bits, 11'h300); // ack 0, stop 1, parity 1, 0x00
      check("b2b_done_total", done_cnt - d0, 2);
      check("b2b_no_error", err_cnt - e0, 0);
      repeat (5) @(negedge clk);
      check("b2b_no_third", bus.ps2_clk_oe, 0);

      // Reset during INHIBIT releases the clock line immediately.
      send(8'hAA);
      repeat (5) @(negedge clk);
      check("inh_clk_oe_before", bus.ps2_clk_oe, 1);
      #2 rst = 1'b0;
      #1;
      check("inh_rst_clk_oe", bus.ps2_clk_oe, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("inh_rst_ready", bus.tx_ready, 1);

      // Reset mid-DATA: byte 0x00 so the host is pulling data low at bit 2.
      send(8'h00);
      t = 0;
      while (bus.ps2_clk_oe && t < 200) begin @(negedge clk); t++; end
      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      check("mid_data_oe_before", bus.ps2_data_oe, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_data_oe", bus.ps2_data_oe, 0);
      check("mid_rst_clk_oe", bus.ps2_clk_oe, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rel_ready", bus.tx_ready, 1);
      check("mid_rel_done", bus.tx_done, 0);
      check("mid_rel_error", bus.tx_error, 0);

      // Timeout: no device on the second instance, so it never sees a falling edge.
      @(negedge clk);
      bus_to.tx_data  = 8'hF4;
      bus_to.tx_valid = 1'b1;
      @(negedge clk);
      bus_to.tx_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (bus_to.ps2_clk_oe && bus_to.ps2_data_oe) got = 1'b1;
      end
      check("to_req_seen", got, 1);
      // n counts the cycles after REQ that precede the error pulse.
      n = 0; got = 1'b0;
      for (int k = 0; k < 2000 && !got; k++) begin
         @(negedge clk);
         if (bus_to.tx_error) got = 1'b1;
         else n++;
      end
      check("to_error_seen", got, 1);
      check("to_latency", n, TIMEOUT_TO);
      check("to_clk_oe", bus_to.ps2_clk_oe, 0);
      check("to_data_oe", bus_to.ps2_data_oe, 0);
      check("to_no_done", bus_to.tx_done, 0);
      @(negedge clk);
      check("to_error_width", bus_to.tx_error, 0);
      check("to_idle_after", bus_to.tx_ready, 1);

      check("pulse_exclusive", both_cnt, 0);
      check("post_pulse_seen", post_seen, 5);
      check("post_pulse_idle", post_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the game logic to the keyboard over the same two open-collector lines the keyboard receiver listens on. It implements the request-to-send sequence, drives bits on device clock edges, and checks the device acknowledge. It sits beside the keyboard receiver at the top level; the top-level tri-states convert the `*_oe` outputs into pad drive.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the PS/2 clock is held low before the start bit (≥100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles from leaving REQ to returning to IDLE (15 ms at 50 MHz).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
tx_data  input  8  command byte to send.
tx_valid  input  1  request; accepted when tx_valid && tx_ready.
tx_ready  output  1  high only in IDLE.
ps2_clk_in  input  1  raw PS/2 clock pad level (asynchronous).
ps2_data_in  input  1  raw PS/2 data pad level (asynchronous).
ps2_clk_oe  output  1  1 = pull the PS/2 clock line low; 0 = release it.
ps2_data_oe  output  1  1 = pull the PS/2 data line low; 0 = release it.
tx_done  output  1  one-cycle pulse on an acknowledged transfer.
tx_error  output  1  one-cycle pulse on a NACK or timeout.

Behaviour:
- Synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser. A falling edge ("fe") is prev_sync=1 and cur_sync=0, registered.
- Reset (rst=0, asynchronous): state=IDLE, tx_ready=1, both oe=0, tx_done=0, tx_error=0, counters and shift register cleared. Lines are released immediately, including mid-transfer. On reset release, operation starts in IDLE.
- Byte capture: on accept, the shift register is loaded with {odd parity = ~^tx_data, tx_data}. tx_data is not sampled again.
- IDLE: tx_ready=1, both oe=0.
  - tx_valid=1 → INHIBIT on the next edge; tx_ready drops the same edge.
  - tx_valid while not in IDLE is ignored; there is no queueing.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: clk_oe=1, data_oe=1 for 1 cycle (start bit asserted before clock release), then START. The timeout counter starts at 0 here.
- START: clk_oe=0, data_oe=1. Edges are ignored until the synced clock is seen high, then DATA with bit index 0. This prevents a false fe from the host's own release.
- DATA: on each fe, data_oe = ~shift[idx] and idx increments. fe 1..8 present bits 0..7 (LSB first); fe 9 presents parity. After fe 9 → STOP.
- STOP: on the next fe (10), data_oe=0 (stop bit 1, line released) → ACK.
- ACK: on the next fe (11), sample synced data.
  - 0 → WAIT_IDLE (acknowledged).
  - 1 → tx_error pulse, then IDLE.
- WAIT_IDLE: wait until synced clk=1 and synced data=1, then tx_done pulse and IDLE.
- Timeout: in START, DATA, STOP, ACK and WAIT_IDLE, the counter increments each cycle. When the count reaches TIMEOUT_CYCLES: tx_error pulse, both oe=0, then IDLE. This rule has priority over an fe in the same cycle.
- Exclusivity: tx_done and tx_error never assert together. Each is high exactly 1 cycle, and the state is IDLE on the following cycle.
- Device-driven clock: clk_oe=0 in every state except INHIBIT and REQ.
- Latency: accept → first clk_oe=1 is 1 cycle. The clock line is held low for INHIBIT_CYCLES+1 cycles in total.

Test Plan:
- Reset: drive rst=0 mid-DATA → both oe=0 within the same cycle; after release, tx_ready=1, tx_done=0, tx_error=0.
- Send 0xED (INHIBIT_CYCLES=20) with a device model clocking at 40-cycle half-periods:
  - clk_oe low 21 cycles, then data_oe low;
  - line levels on fe1..fe9 are 1,0,1,1,0,1,1,1 and parity 1;
  - stop 1; the model ACKs 0 → one tx_done pulse.
- Send 0xF4 → parity bit 0 on fe9; acknowledged → tx_done.
- NACK: the device leaves data high at fe11 → tx_error pulse, no tx_done, IDLE next cycle.
- Timeout (TIMEOUT_CYCLES=500): the device never clocks after REQ → tx_error exactly 500 cycles after REQ, both oe=0.
- Back-to-back: hold tx_valid=1 with 0xFF then 0x00 → second byte accepted only after tx_done. A tx_valid pulse during the first transfer is ignored.
